stream_scoreboard: RTL and testbench

- Synthesizable in-order response checker: the consuming end of a stimulus/expect stream.
- The stimulus side pushes expected words into an internal FIFO.
- The DUT output side presents actual words, which are popped and compared against the FIFO head.
- Reports match/mismatch/unexpected counts, a pending-response timeout and first-error capture for bench or on-chip self-test use.

---
 rtl/stream_scoreboard.sv | 174 +++++++++++++++++
 tb/tb_stream_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_scoreboard.sv
// In-order response checker: expected words queue in a FIFO and each actual word pops and compares against the head.
// Push and compare both take effect at the same edge; expected side backpressures only when full, actual side never.
module stream_scoreboard #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   exp_valid_i,
  input  logic [DATA_W-1:0]      exp_data_i,
  output logic                   exp_ready_o,
  input  logic                   act_valid_i,
  input  logic [DATA_W-1:0]      act_data_i,
  output logic [$clog2(DEPTH):0] pending_o,
  output logic [CNT_W-1:0]       match_cnt_o,
  output logic [CNT_W-1:0]       mismatch_cnt_o,
  output logic [CNT_W-1:0]       unexpected_cnt_o,
  output logic                   timeout_flag_o,
  output logic                   err_sticky_o,
  output logic [DATA_W-1:0]      err_exp_o,
  output logic [DATA_W-1:0]      err_act_o,
  output logic [1:0]             state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    TIMED_OUT = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [CNT_W-1:0]  match_q, match_d, mis_q, mis_d, unexp_q, unexp_d;
  logic              tflag_q, tflag_d, sticky_q, sticky_d;
  logic [DATA_W-1:0] eexp_q, eexp_d, eact_q, eact_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  state_t            state_q, state_d;

  logic              empty, full, push, pop, hit, miss, unexp;
  logic [DATA_W-1:0] head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign head  = mem_q[rd_ptr_q];
  assign push  = exp_valid_i && !full;
  assign pop   = act_valid_i && !empty;
  assign hit   = pop && (head == act_data_i);
  assign miss  = pop && (head != act_data_i);
  assign unexp = act_valid_i && empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    match_d  = match_q;
    mis_d    = mis_q;
    unexp_d  = unexp_q;
    tflag_d  = tflag_q;
    sticky_d = sticky_q;
    eexp_d   = eexp_q;
    eact_d   = eact_q;
    tcnt_d   = tcnt_q;
    state_d  = state_q;

    if (hit) match_d = sat_inc(match_q);
    if (miss) begin
      mis_d    = sat_inc(mis_q);
      sticky_d = 1'b1;
      // mismatch count of zero means no mismatch seen since reset/clear
      if (mis_q == '0) begin
        eexp_d = head;
        eact_d = act_data_i;
      end
    end
    if (unexp) begin
      unexp_d  = sat_inc(unexp_q);
      sticky_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (count_d != '0) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (count_d == '0) begin
          tcnt_d  = '0;
          state_d = IDLE;
        end else if (pop) begin
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_d == TW'(TIMEOUT)) begin
            tflag_d  = 1'b1;
            sticky_d = 1'b1;
            state_d  = TIMED_OUT;
          end
        end
      end
      TIMED_OUT: ;
      default: state_d = IDLE;
    endcase

    // clear discards this cycle's events but lets the FIFO move
    if (clear_i) begin
      match_d  = '0;
      mis_d    = '0;
      unexp_d  = '0;
      tflag_d  = 1'b0;
      sticky_d = 1'b0;
      eexp_d   = '0;
      eact_d   = '0;
      tcnt_d   = '0;
      state_d  = (count_d == '0) ? IDLE : ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= exp_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      match_q  <= '0;
      mis_q    <= '0;
      unexp_q  <= '0;
      tflag_q  <= 1'b0;
      sticky_q <= 1'b0;
      eexp_q   <= '0;
      eact_q   <= '0;
      tcnt_q   <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      match_q  <= match_d;
      mis_q    <= mis_d;
      unexp_q  <= unexp_d;
      tflag_q  <= tflag_d;
      sticky_q <= sticky_d;
      eexp_q   <= eexp_d;
      eact_q   <= eact_d;
      tcnt_q   <= tcnt_d;
      state_q  <= state_d;
    end
  end

  assign exp_ready_o      = !full;
  assign pending_o        = count_q;
  assign match_cnt_o      = match_q;
  assign mismatch_cnt_o   = mis_q;
  assign unexpected_cnt_o = unexp_q;
  assign timeout_flag_o   = tflag_q;
  assign err_sticky_o     = sticky_q;
  assign err_exp_o        = eexp_q;
  assign err_act_o        = eact_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_stream_scoreboard.sv
// Directed bench for stream_scoreboard: a queue model of the expected FIFO tracks pushes and pops each cycle.
module tb_stream_scoreboard;

  logic       clk = 1'b0;
  logic       rst, clear, exp_valid, act_valid;
  logic [7:0] exp_data, act_data;
  logic       exp_ready, timeout_flag, err_sticky;
  logic [4:0] pending;
  logic [15:0] match_cnt, mismatch_cnt, unexpected_cnt;
  logic [7:0] err_exp, err_act;
  logic [1:0] state;

  int checks = 0;
  int passed = 0;

  logic [7:0] mq[$];
  int         m_match, m_mis, m_unexp;
  logic       m_sticky;
  logic [7:0] m_eexp, m_eact;

  stream_scoreboard dut (
    .clk              (clk),
    .rst              (rst),
    .clear_i          (clear),
    .exp_valid_i      (exp_valid),
    .exp_data_i       (exp_data),
    .exp_ready_o      (exp_ready),
    .act_valid_i      (act_valid),
    .act_data_i       (act_data),
    .pending_o        (pending),
    .match_cnt_o      (match_cnt),
    .mismatch_cnt_o   (mismatch_cnt),
    .unexpected_cnt_o (unexpected_cnt),
    .timeout_flag_o   (timeout_flag),
    .err_sticky_o     (err_sticky),
    .err_exp_o        (err_exp),
    .err_act_o        (err_act),
    .state_o          (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic model_zero();
    m_match  = 0;
    m_mis    = 0;
    m_unexp  = 0;
    m_sticky = 1'b0;
    m_eexp   = 8'h00;
    m_eact   = 8'h00;
  endtask

  // One clock: drive on the falling edge, advance the model, check occupancy just after the rising edge.
  task automatic cycle(input logic r, input logic c, input logic ev, input logic [7:0] ed,
                       input logic av, input logic [7:0] ad);
    logic [7:0] h;
    bit was_empty, was_full;
    @(negedge clk);
    rst = r; clear = c; exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad;
    if (r) begin
      mq.delete();
      model_zero();
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == 16);
      if (av && !was_empty) begin
        h = mq.pop_front();
        if (h == ad) m_match++;
        else begin
          if (m_mis == 0) begin
            m_eexp = h;
            m_eact = ad;
          end
          m_mis++;
          m_sticky = 1'b1;
        end
      end
      if (av && was_empty) begin
        m_unexp++;
        m_sticky = 1'b1;
      end
      if (ev && !was_full) mq.push_back(ed);
      if (c) model_zero();
    end
    @(posedge clk);
    #1;
    chk("pending_vs_model", 32'(pending), 32'(mq.size()));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] d);
    cycle(1'b0, 1'b0, 1'b1, d, 1'b0, 8'h00);
  endtask

  task automatic act(input logic [7:0] d);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, d);
  endtask

  task automatic do_clear();
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_match"}, 32'(match_cnt), 32'(m_match));
    chk({tag, "_mismatch"}, 32'(mismatch_cnt), 32'(m_mis));
    chk({tag, "_unexpected"}, 32'(unexpected_cnt), 32'(m_unexp));
    chk({tag, "_sticky"}, 32'(err_sticky), 32'(m_sticky));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_exp_ready"}, 32'(exp_ready), 32'd1);
    chk({tag, "_match"}, 32'(match_cnt), 32'd0);
    chk({tag, "_mismatch"}, 32'(mismatch_cnt), 32'd0);
    chk({tag, "_unexpected"}, 32'(unexpected_cnt), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout_flag), 32'd0);
    chk({tag, "_sticky"}, 32'(err_sticky), 32'd0);
    chk({tag, "_err_exp"}, 32'(err_exp), 32'd0);
    chk({tag, "_err_act"}, 32'(err_act), 32'd0);
    chk({tag, "_state"}, 32'(state), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1; clear = 1'b0; exp_valid = 1'b0; exp_data = 8'h00; act_valid = 1'b0; act_data = 8'h00;
    model_zero();

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    chk_reset_vals("reset");

    // Three matching words in order
    push(8'h11);
    chk("first_push_state", 32'(state), 32'd1);
    push(8'h22);
    push(8'h33);
    act(8'h11);
    act(8'h22);
    act(8'h33);
    chk("inorder_match", 32'(match_cnt), 32'd3);
    chk("inorder_mismatch", 32'(mismatch_cnt), 32'd0);
    chk("inorder_sticky", 32'(err_sticky), 32'd0);
    chk("inorder_state", 32'(state), 32'd0);
    chk_stats("inorder");

    // Two mismatches, first one retained
    do_clear();
    push(8'hA5);
    act(8'h5A);
    push(8'h01);
    act(8'hFF);
    chk("mis_count", 32'(mismatch_cnt), 32'd2);
    chk("mis_err_exp", 32'(err_exp), 32'hA5);
    chk("mis_err_act", 32'(err_act), 32'h5A);
    chk("mis_sticky", 32'(err_sticky), 32'd1);
    chk("mis_err_exp_model", 32'(err_exp), 32'(m_eexp));
    chk_stats("mis");

    // Unexpected act with same-cycle push still stored
    do_clear();
    cycle(1'b0, 1'b0, 1'b1, 8'h7E, 1'b1, 8'h7E);
    chk("unexp_count", 32'(unexpected_cnt), 32'd1);
    chk("unexp_pending", 32'(pending), 32'd1);
    chk("unexp_sticky", 32'(err_sticky), 32'd1);
    chk("unexp_match", 32'(match_cnt), 32'd0);
    act(8'h7E);
    chk("unexp_stored_match", 32'(match_cnt), 32'd1);
    chk_stats("unexp");

    // Fill, drop on full (also with a same-cycle pop), drain across pointer wrap
    do_clear();
    for (int i = 0; i < 16; i++) begin
      w = 8'((i * 37) + 5);
      push(w);
    end
    chk("full_pending", 32'(pending), 32'd16);
    chk("full_ready", 32'(exp_ready), 32'd0);
    push(8'hEE);
    chk("full_drop_pending", 32'(pending), 32'd16);
    cycle(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1, 8'h05);
    chk("full_pop_drop_pending", 32'(pending), 32'd15);
    for (int i = 1; i < 16; i++) begin
      w = 8'((i * 37) + 5);
      act(w);
    end
    chk("drain_match", 32'(match_cnt), 32'd16);
    chk("drain_mismatch", 32'(mismatch_cnt), 32'd0);
    chk("drain_pending", 32'(pending), 32'd0);
    chk("drain_ready", 32'(exp_ready), 32'd1);
    chk_stats("drain");

    // Timeout exactly 32 edges after the push edge
    do_clear();
    push(8'h42);
    for (int i = 0; i < 31; i++) idle();
    chk("timeout_not_yet_flag", 32'(timeout_flag), 32'd0);
    chk("timeout_not_yet_state", 32'(state), 32'd1);
    idle();
    chk("timeout_flag", 32'(timeout_flag), 32'd1);
    chk("timeout_state", 32'(state), 32'd2);
    chk("timeout_sticky", 32'(err_sticky), 32'd1);
    act(8'h42);
    chk("timeout_match", 32'(match_cnt), 32'd1);
    chk("timeout_state_hold", 32'(state), 32'd2);
    chk("timeout_pending", 32'(pending), 32'd0);
    do_clear();
    chk_reset_vals("after_clear");

    // Reset mid-stream, with clear also asserted
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    chk("pre_rst_pending", 32'(pending), 32'd4);
    cycle(1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 8'h00);
    chk_reset_vals("mid_rst");
    act(8'h12);
    chk("post_rst_unexp", 32'(unexpected_cnt), 32'd1);
    chk("post_rst_sticky", 32'(err_sticky), 32'd1);
    chk("post_rst_match", 32'(match_cnt), 32'd0);
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
